// File: rtl/rpn_stack_calc.sv
// ---------------------------------------------------------------------------
// rpn_stack_calc
//    Reverse-Polish integer stack calculator. The top two entries live in
//    registers (tos, nos); deeper entries spill into a synchronous RAM.
//    Ops that shrink the stack while deeper entries exist spend one extra
//    REFILL cycle reloading nos from the RAM.
//
// Configuration:
//    RPN_STACK_MUL_EN  defined   -> op 3 is MUL (multiplier present)
//                      undefined -> op 3 is illegal, always rejected
//
// Ports:
//    clk        in   rising-edge clock
//    nrst       in   asynchronous active-low reset
//    cmd_valid  in   command present
//    cmd_ready  out  high in IDLE; command accepted when valid & ready
//    op[2:0]    in   0 PUSH,1 NEG,2 ADD,3 MUL,4 SUB,5 DUP,6 SWAP,7 POP
//    d[W-1:0]   in   PUSH operand
//    top        out  top-of-stack value, 0 when empty
//    cnt        out  current entry count
//    empty      out  cnt == 0
//    full       out  cnt == DEPTH
//    err        out  one-cycle pulse after an accepted-but-rejected command
// ---------------------------------------------------------------------------
module rpn_stack_calc #(
   parameter int W     = 16,
   parameter int DEPTH = 1000,
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    op,
   input  logic [W-1:0]  d,
   output logic [W-1:0]  top,
   output logic [CW-1:0] cnt,
   output logic          empty,
   output logic          full,
   output logic          err
);

   // Entries 3..DEPTH spill into the RAM.
   localparam int RD = DEPTH - 2;
   localparam int AW = (RD > 1) ? $clog2(RD) : 1;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] REFILL = 1'b1;

   localparam logic [2:0] OP_PUSH = 3'd0;
   localparam logic [2:0] OP_NEG  = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_MUL  = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;
   localparam logic [2:0] OP_DUP  = 3'd5;
   localparam logic [2:0] OP_SWAP = 3'd6;
   localparam logic [2:0] OP_POP  = 3'd7;

   logic [0:0]    state;
   logic [W-1:0]  tos, nos;
   logic [CW-1:0] cnt_q;
   logic          err_q;

   logic [W-1:0]  ram [RD];
   logic [W-1:0]  rd_data;

   logic          accept, reject, do_op, shrink, refill_go, ram_we;
   logic          lt1, lt2, at_full;
   logic [W-1:0]  tos_n, nos_n;
   logic [CW-1:0] cnt_n;
   logic [AW-1:0] wr_idx, rd_idx;

   assign lt1     = (cnt_q == '0);
   assign lt2     = (cnt_q < CW'(2));
   assign at_full = (cnt_q == CW'(DEPTH));
   assign accept  = cmd_valid && (state == IDLE);

   // Legality check and next-value computation for the accepted command.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      reject = 1'b0;
      shrink = 1'b0;
      tos_n  = tos;
      nos_n  = nos;
      cnt_n  = cnt_q;
      case (op)
         OP_PUSH: begin
            reject = at_full;
            tos_n  = d;
            nos_n  = tos;
            cnt_n  = cnt_q + CW'(1);
         end
         OP_DUP: begin
            reject = lt1 || at_full;
            nos_n  = tos;
            cnt_n  = cnt_q + CW'(1);
         end
         OP_NEG: begin
            reject = lt1;
            tos_n  = '0 - tos;
         end
         OP_ADD: begin
            reject = lt2;
            shrink = 1'b1;
            tos_n  = nos + tos;
            cnt_n  = cnt_q - CW'(1);
         end
         OP_SUB: begin
            reject = lt2;
            shrink = 1'b1;
            tos_n  = nos - tos;
            cnt_n  = cnt_q - CW'(1);
         end
         OP_MUL: begin
`ifdef RPN_STACK_MUL_EN
            reject = lt2;
            shrink = 1'b1;
            tos_n  = nos * tos;
            cnt_n  = cnt_q - CW'(1);
`else
            reject = 1'b1;
`endif
         end
         OP_SWAP: begin
            reject = lt2;
            tos_n  = nos;
            nos_n  = tos;
         end
         default: begin // OP_POP
            reject = lt1;
            shrink = 1'b1;
            tos_n  = nos;
            cnt_n  = cnt_q - CW'(1);
         end
      endcase
   end

   assign do_op     = accept && !reject;
   // Only when a third entry exists does nos need reloading from the RAM.
   assign refill_go = do_op && shrink && (cnt_q >= CW'(3));
   assign ram_we    = do_op && ((op == OP_PUSH) || (op == OP_DUP)) && !lt2;
   assign wr_idx    = AW'(cnt_q - CW'(2));
   assign rd_idx    = AW'(cnt_q - CW'(3));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
         tos   <= '0;
         nos   <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         err_q <= accept && reject;
         case (state)
            IDLE: begin
               if (do_op) begin
                  tos   <= tos_n;
                  nos   <= nos_n;
                  cnt_q <= cnt_n;
               end
               if (refill_go)
                  state <= REFILL;
            end
            default: begin // REFILL
               nos   <= rd_data;
               state <= IDLE;
            end
         endcase
      end
   end

   // NOTE: spill RAM and its read register carry no reset; cnt alone says what is valid.
   always_ff @(posedge clk) begin
      if (ram_we)
         ram[wr_idx] <= nos;
      if (refill_go)
         rd_data <= ram[rd_idx];
   end

   assign cmd_ready = (state == IDLE);
   // tos may hold a stale value after the last entry is popped.
   assign top       = lt1 ? '0 : tos;
   assign cnt       = cnt_q;
   assign empty     = lt1;
   assign full      = at_full;
   assign err       = err_q;

endmodule
